// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave's state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Byte-lane enables for a legal (aligned, size <= word) transfer.
  function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                              input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << offset;
      HSIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM with per-byte-lane write enables and an
// asynchronous read port sharing the single registered word index.
module ahb_sram_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Update only the enabled byte lanes; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: decodes address phases, inserts optional wait
// states, performs masked reads/writes and answers illegal transfers
// with a two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [3:0]    HPROT,
  input  logic [1:0]    HTRANS,
  input  logic          HMASTLOCK,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA
);

  import ahb_pkg::*;

  slave_state_e          state, state_next;
  logic [3:0]            wait_cnt, wait_cnt_next;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            byte_off;
  logic [2:0]            size_q;
  logic                  write_q;
  logic                  accept;
  logic                  addr_err;
  logic [3:0]            lane_we;
  logic [31:0]           array_rdata;
  logic                  unused_ahb;

  assign unused_ahb = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // The slave only starts a new transfer while its own data phase is
  // completing, so a stray address phase during a stall is ignored even
  // if the interconnect's HREADY is not wired back.
  assign accept = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  assign addr_err = (HSIZE > HSIZE_WORD) ||
                    ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) ||
                    ((HADDR >> (DEPTH_LOG2 + 2)) != '0);

  // State, wait counter and address-phase capture registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      word_idx <= '0;
      byte_off <= 2'b00;
      size_q   <= HSIZE_BYTE;
      write_q  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        word_idx <= HADDR[DEPTH_LOG2+1:2];
        byte_off <= HADDR[1:0];
        size_q   <= HSIZE;
        write_q  <= HWRITE;
      end
    end
  end

  // Next-state logic; completing states may chain straight into a new transfer.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = ST_DATA;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: begin
        if (accept) begin
          if (addr_err) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = 4'(WAIT_STATES - 1);
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Bus-facing outputs and array write strobes decoded from the state.
  always_comb begin
    HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    HRDATA    = '0;
    if ((state == ST_WAIT) || (state == ST_DATA)) begin
      HRDATA = array_rdata;
    end
    lane_we = 4'b0000;
    if ((state == ST_DATA) && write_q) begin
      lane_we = byte_enables(size_q, byte_off);
    end
  end

  ahb_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (HCLK),
    .we    (lane_we),
    .addr  (word_idx),
    .wdata (HWDATA),
    .rdata (array_rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for the AHB-Lite SRAM slave: a zero-wait instance and a
// three-wait-state instance share the address/data bus.
module tb_ahb_lite_sram_slave;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  logic        HCLK;
  logic        hreset;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hreadyout0, hresp0;
  logic [31:0] hrdata0;
  logic        hreadyout3, hresp3;
  logic [31:0] hrdata3;

  int tests_run;
  int tests_failed;

  ahb_lite_sram_slave #(.AW(32), .DW(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans),
    .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hreadyout0),
    .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb_lite_sram_slave #(.AW(32), .DW(32), .DEPTH_LOG2(10), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans),
    .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hreadyout3),
    .HREADYOUT(hreadyout3), .HRESP(hresp3), .HRDATA(hrdata3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] s);
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = 2'b10;
  endtask

  task automatic drive_idle();
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic bus_write0(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    drive_addr(a, 1'b1, s);
    tick();
    hwdata = d;
    drive_idle();
    tick();
  endtask

  task automatic bus_read0(input logic [31:0] a, output logic [31:0] d);
    drive_addr(a, 1'b0, SZ_WORD);
    tick();
    d = hrdata0;
    drive_idle();
    tick();
  endtask

  task automatic wait_ready3(output int lows);
    lows = 0;
    while (!hreadyout3 && lows < 20) begin
      lows++;
      tick();
    end
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    tick();
    tick();
    hreset = 1'b0;
    tests_run++;
    if (hreadyout0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_hreadyout0: got %b expected 1", hreadyout0); end
    tests_run++;
    if (hresp0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hresp0: got %b expected 0", hresp0); end
    tests_run++;
    if (hrdata0 !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hrdata0: got %h expected 00000000", hrdata0); end
    tests_run++;
    if (hreadyout3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_hreadyout3: got %b expected 1", hreadyout3); end
    tests_run++;
    if (hresp3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hresp3: got %b expected 0", hresp3); end
    tests_run++;
    if (hrdata3 !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hrdata3: got %h expected 00000000", hrdata3); end
  endtask

  task automatic test_word_rw();
    hsel0 = 1'b1;
    drive_addr(32'h10, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'hDEADBEEF;
    drive_idle();
    tests_run++;
    if (hreadyout0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL word_write_ready: got %b expected 1", hreadyout0); end
    tick();
    drive_addr(32'h10, 1'b0, SZ_WORD);
    tick();
    tests_run++;
    if (hrdata0 !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL word_read_data: got %h expected deadbeef", hrdata0); end
    tests_run++;
    if (hresp0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL word_read_resp: got %b expected 0", hresp0); end
    tests_run++;
    if (hreadyout0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL word_read_ready: got %b expected 1", hreadyout0); end
    drive_idle();
    tick();
  endtask

  task automatic test_byte_half();
    logic [31:0] d;
    bus_write0(32'h10, SZ_WORD, 32'h11223344);
    bus_write0(32'h13, SZ_BYTE, 32'hAA000000);
    bus_read0(32'h10, d);
    tests_run++;
    if (d !== 32'hAA223344) begin tests_failed++; $display("[TB] FAIL byte_write: got %h expected aa223344", d); end
    bus_write0(32'h12, SZ_HALF, 32'h55660000);
    bus_read0(32'h10, d);
    tests_run++;
    if (d !== 32'h55663344) begin tests_failed++; $display("[TB] FAIL half_write: got %h expected 55663344", d); end
  endtask

  task automatic test_back_to_back();
    drive_addr(32'h20, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'hCAFEF00D;
    drive_addr(32'h20, 1'b0, SZ_WORD);
    tests_run++;
    if (hreadyout0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_write_ready: got %b expected 1", hreadyout0); end
    tick();
    drive_idle();
    tests_run++;
    if (hreadyout0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_read_ready: got %b expected 1", hreadyout0); end
    tests_run++;
    if (hrdata0 !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL b2b_read_data: got %h expected cafef00d", hrdata0); end
    tick();
  endtask

  task automatic test_wait_states();
    int lows;
    hsel0 = 1'b0;
    hsel3 = 1'b1;
    drive_addr(32'h40, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'h0BADC0DE;
    drive_idle();
    wait_ready3(lows);
    tests_run++;
    if (lows !== 3) begin tests_failed++; $display("[TB] FAIL wait_write_lows: got %0d expected 3", lows); end
    tick();
    drive_addr(32'h40, 1'b0, SZ_WORD);
    tick();
    drive_idle();
    wait_ready3(lows);
    tests_run++;
    if (lows !== 3) begin tests_failed++; $display("[TB] FAIL wait_read_lows: got %0d expected 3", lows); end
    tests_run++;
    if (hrdata3 !== 32'h0BADC0DE) begin tests_failed++; $display("[TB] FAIL wait_read_data: got %h expected 0badc0de", hrdata3); end
    tests_run++;
    if (hresp3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL wait_read_resp: got %b expected 0", hresp3); end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] d;
    hsel3 = 1'b0;
    hsel0 = 1'b1;
    bus_write0(32'h0, SZ_WORD, 32'h01020304);
    // misaligned word write
    drive_addr(32'h12, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'hFFFFFFFF;
    drive_idle();
    tests_run++;
    if (hreadyout0 !== 1'b0 || hresp0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_err1: got rdy=%b resp=%b expected rdy=0 resp=1", hreadyout0, hresp0); end
    tick();
    tests_run++;
    if (hreadyout0 !== 1'b1 || hresp0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_err2: got rdy=%b resp=%b expected rdy=1 resp=1", hreadyout0, hresp0); end
    tests_run++;
    if (hrdata0 !== 32'h0) begin tests_failed++; $display("[TB] FAIL misalign_err_rdata: got %h expected 00000000", hrdata0); end
    tick();
    // out-of-range write, with a read presented during ERR1 and again in ERR2
    drive_addr(32'h1000, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'hFFFFFFFF;
    drive_addr(32'h10, 1'b0, SZ_WORD);
    tests_run++;
    if (hreadyout0 !== 1'b0 || hresp0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL range_err1: got rdy=%b resp=%b expected rdy=0 resp=1", hreadyout0, hresp0); end
    tick();
    drive_addr(32'h0, 1'b0, SZ_WORD);
    tests_run++;
    if (hreadyout0 !== 1'b1 || hresp0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL range_err2: got rdy=%b resp=%b expected rdy=1 resp=1", hreadyout0, hresp0); end
    tick();
    drive_idle();
    tests_run++;
    if (hrdata0 !== 32'h01020304 || hresp0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL after_err_read: got data=%h resp=%b expected data=01020304 resp=0", hrdata0, hresp0); end
    tick();
    // oversize transfer
    drive_addr(32'h10, 1'b1, 3'b011);
    tick();
    hwdata = 32'hFFFFFFFF;
    drive_idle();
    tests_run++;
    if (hreadyout0 !== 1'b0 || hresp0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL size_err1: got rdy=%b resp=%b expected rdy=0 resp=1", hreadyout0, hresp0); end
    tick();
    tick();
    bus_read0(32'h10, d);
    tests_run++;
    if (d !== 32'h55663344) begin tests_failed++; $display("[TB] FAIL err_mem_unchanged: got %h expected 55663344", d); end
  endtask

  task automatic test_reset_during_wait();
    int lows;
    hsel0 = 1'b0;
    hsel3 = 1'b1;
    drive_addr(32'h40, 1'b1, SZ_WORD);
    tick();
    hwdata = 32'h12345678;
    drive_idle();
    tick();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    tests_run++;
    if (hreadyout3 !== 1'b1 || hresp3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait_outputs: got rdy=%b resp=%b expected rdy=1 resp=0", hreadyout3, hresp3); end
    tests_run++;
    if (hrdata3 !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_wait_rdata: got %h expected 00000000", hrdata3); end
    tick();
    drive_addr(32'h40, 1'b0, SZ_WORD);
    tick();
    drive_idle();
    wait_ready3(lows);
    tests_run++;
    if (hrdata3 !== 32'h0BADC0DE) begin tests_failed++; $display("[TB] FAIL rst_wait_mem: got %h expected 0badc0de", hrdata3); end
    tests_run++;
    if (lows !== 3) begin tests_failed++; $display("[TB] FAIL rst_wait_lows: got %0d expected 3", lows); end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    hreset = 1'b1;
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = SZ_WORD;
    htrans = 2'b00;
    hwdata = 32'h0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_reset_during_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

AHB-Lite slave with an on-chip word-addressed SRAM array, sitting directly downstream of the `ahb_lite_m` master on the same HCLK domain and completing the transfers that master issues. It decodes each address phase, inserts a programmable number of wait states, performs byte/halfword/word reads and writes with byte-lane masking, and returns a two-cycle ERROR response for illegal transfers. It is the standard bus-functional target for master bring-up and the first real memory slave in the fabric.

## Interface
- AW, 32, address width (HADDR width)
- DW, 32, data width; fixed at 32 for this block
- DEPTH_LOG2, 10, log2 of array depth in words (default 4 KiB)
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15)

Clock and reset: one clock; reset is synchronous and active-high.
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  AW  address
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (ignored)
- HPROT  in  4  protection (ignored)
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  lock (ignored)
- HWDATA  in  DW  write data (data phase)
- HREADY  in  1  bus-level ready (end of previous data phase)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DW  read data

## Operation
- Accept: address phase sampled on HCLK edge when HSEL & HREADY & HTRANS[1]. Registered: word index, byte offset, HSIZE, HWRITE, error flag.
- Not accepted (HTRANS IDLE/BUSY, HSEL=0, HREADY=0): no access; next data phase is zero-wait OKAY.
- Error flag set when: HSIZE > 3'b010; misaligned (halfword with HADDR[0]=1, word with HADDR[1:0]!=0); HADDR[AW-1:DEPTH_LOG2+2] != 0.
- FSM states: IDLE (no pending transfer, HREADYOUT=1, HRESP=0); WAIT (counter runs, HREADYOUT=0); DATA (HREADYOUT=1, transfer completes); ERR1 (HREADYOUT=0, HRESP=1); ERR2 (HREADYOUT=1, HRESP=1).
- Transitions: accept & error -> ERR1 -> ERR2; accept & WAIT_STATES>0 -> WAIT for WAIT_STATES cycles -> DATA; accept & WAIT_STATES=0 -> DATA. From DATA/ERR2/IDLE a new accept on the same edge restarts the sequence (back-to-back pipelining); otherwise -> IDLE.
- Write: byte enables from size/offset (byte: 1 lane, halfword: lanes {1:0} or {3:2}, word: all). Array lanes updated at end of DATA cycle from HWDATA. Errored writes never modify the array.
- Read: array read combinationally from registered word index; HRDATA = full word in WAIT and DATA states, 0 otherwise (including error states).
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM -> IDLE, wait counter 0; a pending transfer is discarded without writing. Array contents are not reset.

## Timing
- Zero-wait read: address phase cycle T, HRDATA valid with HREADYOUT=1 in T+1.
- Zero-wait write: HWDATA sampled in T+1, array updated at end of T+1; a read with address phase in T+1 (data phase T+2) returns the new data. No forwarding is required.
- N wait states: HREADYOUT low for cycles T+1..T+N, completion at T+N+1.
- Error: HREADYOUT=0/HRESP=1 in T+1, HREADYOUT=1/HRESP=1 in T+2. An address phase presented in T+1 is ignored (HREADY low); one presented in T+2 is accepted.

## Structure
- Shared package `ahb_pkg`: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, HRESP OKAY/ERROR, and the FSM state typedef.
- One sub-module: `ahb_sram_array` (DEPTH words x 32 bits, 4 byte-lane write enables, combinational read port).

## Test plan
- Word write 0xDEADBEEF @0x10, then read @0x10 (0 waits) -> HRDATA=0xDEADBEEF in the cycle after the read address phase, HRESP=0.
- Byte write 0xAA @0x13 over word 0x11223344 -> read @0x10 returns 0xAA223344. Halfword write 0x5566 @0x12 -> 0x55663344.
- Back-to-back write @0x20 then read @0x20 in consecutive address phases -> read returns the written value with no stall.
- WAIT_STATES=3, read -> HREADYOUT low for exactly 3 cycles, data on the 4th cycle.
- Word access @0x02, and access @(1<<(DEPTH_LOG2+2)) -> two-cycle ERROR each; a subsequent read shows memory unchanged.
- HRESET asserted during a WAIT state of a write -> HREADYOUT=1/HRESP=0 on the next cycle; target word unchanged.
